// File: rtl/vga_rect_fill_engine_pkg.sv
// Shared definitions for the VGA video-memory writers: widths, FSM states, colours.
package vga_defs;

   localparam int unsigned VGA_COORD_W = 8;
   localparam int unsigned VGA_COLOR_W = 3;
   localparam int unsigned VGA_ADDR_W  = 2 * VGA_COORD_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Pixel colours, {R,G,B}
   localparam logic [VGA_COLOR_W-1:0] COLOR_BLACK   = 3'b000;
   localparam logic [VGA_COLOR_W-1:0] COLOR_BLUE    = 3'b001;
   localparam logic [VGA_COLOR_W-1:0] COLOR_GREEN   = 3'b010;
   localparam logic [VGA_COLOR_W-1:0] COLOR_CYAN    = 3'b011;
   localparam logic [VGA_COLOR_W-1:0] COLOR_RED     = 3'b100;
   localparam logic [VGA_COLOR_W-1:0] COLOR_MAGENTA = 3'b101;
   localparam logic [VGA_COLOR_W-1:0] COLOR_YELLOW  = 3'b110;
   localparam logic [VGA_COLOR_W-1:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/vga_rect_fill_engine_scan.sv
// Row-major x/y scan counter for a rectangle; x reloads from its start column at row end.
module rect_scan_counter #(
   parameter int unsigned COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               advance,
   input  logic [COORD_W-1:0] ld_x,
   input  logic [COORD_W-1:0] ld_y,
   input  logic [COORD_W-1:0] ld_x_end,
   input  logic [COORD_W-1:0] ld_y_end,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last
);

   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [COORD_W-1:0] x_start_q, x_start_d;
   logic [COORD_W-1:0] x_end_q, x_end_d;
   logic [COORD_W-1:0] y_end_q, y_end_d;

   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      x_start_d = x_start_q;
      x_end_d   = x_end_q;
      y_end_d   = y_end_q;
      if (load) begin
         x_d       = ld_x;
         y_d       = ld_y;
         x_start_d = ld_x;
         x_end_d   = ld_x_end;
         y_end_d   = ld_y_end;
      end else if (advance) begin
         if (x_q < x_end_q) begin
            x_d = x_q + 1'b1;
         end else begin
            x_d = x_start_q;
            y_d = y_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         x_start_q <= '0;
         x_end_q   <= '0;
         y_end_q   <= '0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         x_start_q <= x_start_d;
         x_end_q   <= x_end_d;
         y_end_q   <= y_end_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = (x_q == x_end_q) && (y_q == y_end_q);

endmodule

// File: rtl/vga_rect_fill_engine.sv
// Rectangle-fill writer for the 256x256 video RAM: one command in, one pixel write per clock.
module vga_rect_fill_engine
   import vga_defs::*;
#(
   parameter int unsigned COORD_W = VGA_COORD_W,
   parameter int unsigned COLOR_W = VGA_COLOR_W
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [COORD_W-1:0]   iX0,
   input  logic [COORD_W-1:0]   iY0,
   input  logic [COORD_W-1:0]   iWidth,
   input  logic [COORD_W-1:0]   iHeight,
   input  logic [COLOR_W-1:0]   iColor,
   input  logic                 iCommand_Ready,
   input  logic                 iHold,
   output logic                 oReadyForCommand,
   output logic                 oBusy,
   output logic                 oDone,
   output logic                 oWriteEnable,
   output logic [2*COORD_W-1:0] oWriteAddress,
   output logic [COLOR_W-1:0]   oDataOut
);

   state_e             state_q, state_d;
   logic               ready_q, ready_d;
   logic [COLOR_W-1:0] color_q, color_d;

   logic               accept;
   logic               step;
   logic               advance;
   logic               last;
   logic [COORD_W:0]   x_sum;
   logic [COORD_W:0]   y_sum;
   logic [COORD_W-1:0] x_end;
   logic [COORD_W-1:0] y_end;
   logic [COORD_W-1:0] x_cur;
   logic [COORD_W-1:0] y_cur;

   // End coordinates saturate at the screen edge instead of wrapping to 0
   always_comb begin
      x_sum = {1'b0, iX0} + {1'b0, iWidth};
      y_sum = {1'b0, iY0} + {1'b0, iHeight};
      x_end = x_sum[COORD_W] ? '1 : x_sum[COORD_W-1:0];
      y_end = y_sum[COORD_W] ? '1 : y_sum[COORD_W-1:0];
   end

   assign accept  = (state_q == ST_IDLE) && ready_q && iCommand_Ready;
   assign step    = (state_q == ST_FILL) && !iHold;
   assign advance = step && !last;

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_FILL;
               color_d = iColor;
            end
         end
         ST_FILL: begin
            if (step && last) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         color_q <= color_d;
      end
   end

   rect_scan_counter #(
      .COORD_W (COORD_W)
   ) u_scan (
      .clk      (Clock),
      .rst_n    (Reset),
      .load     (accept),
      .advance  (advance),
      .ld_x     (iX0),
      .ld_y     (iY0),
      .ld_x_end (x_end),
      .ld_y_end (y_end),
      .x        (x_cur),
      .y        (y_cur),
      .last     (last)
   );

   assign oReadyForCommand = ready_q;
   assign oBusy            = (state_q == ST_FILL);
   assign oDone            = (state_q == ST_DONE);
   assign oWriteEnable     = step;
   assign oWriteAddress    = {x_cur, y_cur};
   assign oDataOut         = color_q;

endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// Directed bench for vga_rect_fill_engine: command table with write scoreboard plus reset sequences.
module tb_vga_rect_fill_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  x0 = '0, y0 = '0, wd = '0, ht = '0;
   logic [2:0]  col = '0;
   logic        cmd = 1'b0;
   logic        hold = 1'b0;
   logic        ready, busy, done, we;
   logic [15:0] addr;
   logic [2:0]  dout;

   int checks = 0;
   int failures = 0;

   logic [2:0]  ram_act [0:65535];
   logic [2:0]  ram_exp [0:65535];
   logic [15:0] exp_q [$];
   logic [15:0] act_q [$];

   typedef struct {
      logic [7:0]  x0, y0, w, h;
      logic [2:0]  col;
      int          hold_a, hold_b;
      int          exp_writes;
      int          exp_fill;
      logic [15:0] exp_last;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   vga_rect_fill_engine #(
      .COORD_W (8),
      .COLOR_W (3)
   ) dut (
      .Clock            (clk),
      .Reset            (rst_n),
      .iX0              (x0),
      .iY0              (y0),
      .iWidth           (wd),
      .iHeight          (ht),
      .iColor           (col),
      .iCommand_Ready   (cmd),
      .iHold            (hold),
      .oReadyForCommand (ready),
      .oBusy            (busy),
      .oDone            (done),
      .oWriteEnable     (we),
      .oWriteAddress    (addr),
      .oDataOut         (dout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int xe, ye, cyc, fill, dones, done_cyc, last_wr, data_bad, seq_bad, busy_at_done;
      exp_q.delete();
      act_q.delete();
      xe = int'(v.x0) + int'(v.w);
      ye = int'(v.y0) + int'(v.h);
      if (xe > 255) xe = 255;
      if (ye > 255) ye = 255;
      for (int yy = int'(v.y0); yy <= ye; yy++) begin
         for (int xx = int'(v.x0); xx <= xe; xx++) begin
            exp_q.push_back(16'(xx * 256 + yy));
            ram_exp[xx * 256 + yy] = v.col;
         end
      end

      @(negedge clk);
      #1;
      check($sformatf("v%0d_ready_before", idx), 32'(ready), 32'd1);
      x0 = v.x0; y0 = v.y0; wd = v.w; ht = v.h; col = v.col; cmd = 1'b1; hold = 1'b0;
      @(negedge clk);
      cmd = 1'b0;
      // operands only matter at the acceptance edge
      x0 = 8'($urandom); y0 = 8'($urandom); wd = 8'($urandom); ht = 8'($urandom); col = 3'($urandom);

      cyc = 0; fill = 0; dones = 0; done_cyc = -1; last_wr = -1;
      data_bad = 0; busy_at_done = 0;
      while (1) begin
         cyc++;
         hold = (cyc == v.hold_a) || (cyc == v.hold_b);
         #1;
         if (busy) fill++;
         if (busy && hold && act_q.size() < exp_q.size())
            check($sformatf("v%0d_held_addr", idx), 32'(addr), 32'(exp_q[act_q.size()]));
         if (we) begin
            act_q.push_back(addr);
            ram_act[addr] = dout;
            if (dout !== v.col) data_bad++;
            last_wr = cyc;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
         end
         if (done || cyc >= 70000) break;
         @(negedge clk);
      end
      hold = 1'b0;

      check($sformatf("v%0d_done_seen", idx), 32'(dones), 32'd1);
      check($sformatf("v%0d_writes", idx), 32'(act_q.size()), 32'(v.exp_writes));
      check($sformatf("v%0d_fill_cycles", idx), 32'(fill), 32'(v.exp_fill));
      if (act_q.size() > 0)
         check($sformatf("v%0d_last_addr", idx), 32'(act_q[act_q.size()-1]), 32'(v.exp_last));
      seq_bad = 0;
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         if (act_q[i] !== exp_q[i]) seq_bad++;
      check($sformatf("v%0d_seq_mismatches", idx), 32'(seq_bad), 32'd0);
      check($sformatf("v%0d_data_mismatches", idx), 32'(data_bad), 32'd0);
      check($sformatf("v%0d_done_after_last", idx), 32'(done_cyc), 32'(last_wr + 1));
      check($sformatf("v%0d_busy_at_done", idx), 32'(busy_at_done), 32'd0);

      @(negedge clk);
      #1;
      check($sformatf("v%0d_done_single", idx), 32'(done), 32'd0);
      check($sformatf("v%0d_ready_after", idx), 32'(ready), 32'd1);
   endtask

   initial begin
      int bad, n, cyc;

      for (int i = 0; i < 65536; i++) begin
         ram_act[i] = '0;
         ram_exp[i] = '0;
      end

      //              x0    y0    w     h     col     ha hb  writes fill   last
      vecs[0] = '{8'd10,  8'd20,  8'd2,   8'd1,   3'b100, 0, 0, 6,     6,     16'h0A14 + 16'h0201};
      vecs[1] = '{8'd254, 8'd255, 8'd5,   8'd3,   3'b010, 0, 0, 2,     2,     16'hFFFF};
      vecs[2] = '{8'd0,   8'd0,   8'd3,   8'd0,   3'b001, 2, 3, 4,     6,     16'h0300};
      vecs[3] = '{8'd100, 8'd50,  8'd0,   8'd0,   3'b111, 0, 0, 1,     1,     16'h6432};
      vecs[4] = '{8'd250, 8'd10,  8'd10,  8'd0,   3'b101, 0, 0, 6,     6,     16'hFF0A};
      vecs[5] = '{8'd0,   8'd0,   8'd255, 8'd255, 3'b110, 0, 0, 65536, 65536, 16'hFFFF};

      // reset held for 3 clocks
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("rst_outputs", {26'd0, ready, busy, done, we, |addr, |dout}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_before_first_edge", 32'(ready), 32'd0);
      @(posedge clk);
      #1;
      check("ready_first_edge", 32'(ready), 32'd1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      bad = 0;
      for (int i = 0; i < 65536; i++)
         if (ram_act[i] !== ram_exp[i]) bad++;
      check("ram_scoreboard", 32'(bad), 32'd0);

      // 16x16 fill, second command mid-fill, reset after 5 writes
      act_q.delete();
      @(negedge clk);
      #1;
      check("mf_ready_before", 32'(ready), 32'd1);
      x0 = 8'd0; y0 = 8'd0; wd = 8'd15; ht = 8'd15; col = 3'b011; cmd = 1'b1;
      @(negedge clk);
      cmd = 1'b0;
      n = 0; cyc = 0;
      while (n < 5 && cyc < 50) begin
         cyc++;
         cmd = (cyc == 2);
         if (cyc == 2) begin
            x0 = 8'd200; y0 = 8'd200; wd = 8'd0; ht = 8'd0; col = 3'b111;
         end
         #1;
         if (we) begin
            act_q.push_back(addr);
            n++;
         end
         check("mf_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end
      cmd = 1'b0;
      check("mf_writes_before_reset", 32'(n), 32'd5);
      for (int i = 0; i < act_q.size(); i++)
         check($sformatf("mf_addr%0d", i), 32'(act_q[i]), 32'(i * 256));
      #1;
      check("mf_we_pending", 32'(we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mf_we_async_drop", 32'(we), 32'd0);
      check("mf_busy_async_drop", 32'(busy), 32'd0);
      check("mf_addr_reset", 32'(addr), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check("mf_in_reset_quiet", {29'd0, we, done, ready}, 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mf_ready_after_release", 32'(ready), 32'd1);
      check("mf_no_done_after", 32'(done), 32'd0);
      check("mf_idle_no_we", 32'(we), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_rect_fill_engine.md
Name: vga_rect_fill_engine

Overview:
- Hardware rectangle-fill writer for the 256x256, 3-bit video memory that the VGA controller scans out.
- Accepts one fill command per handshake: origin, size, colour.
- Drives the video-RAM write port at one pixel per clock.
- Offloads the per-pixel VGA instruction loop from MiniAlu; the core issues one command and polls or waits for completion.

Parameters:
- COORD_W, 8, bits per coordinate. Video address width is 2*COORD_W.
- COLOR_W, 3, pixel colour width ({R,G,B}).

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-low reset.
- iX0  in  COORD_W  left column of the rectangle.
- iY0  in  COORD_W  top row of the rectangle.
- iWidth  in  COORD_W  number of columns minus 1.
- iHeight  in  COORD_W  number of rows minus 1.
- iColor  in  COLOR_W  fill colour.
- iCommand_Ready  in  1  command valid; the command is accepted when this and oReadyForCommand are both high.
- iHold  in  1  freeze request while another writer owns the video-RAM port.
- oReadyForCommand  out  1  engine idle and able to accept a command.
- oBusy  out  1  a fill is in progress.
- oDone  out  1  one-cycle pulse when a fill completes.
- oWriteEnable  out  1  video-RAM write strobe.
- oWriteAddress  out  2*COORD_W  video-RAM address, {x,y} (x*256+y).
- oDataOut  out  COLOR_W  video-RAM write data.

Behaviour:
- Reset (async, low):
  - State goes to IDLE.
  - oReadyForCommand=0, oBusy=0, oDone=0, oWriteEnable=0, oWriteAddress=0, oDataOut=0.
  - oReadyForCommand rises at the first Clock edge after Reset is released.
- States are IDLE, FILL and DONE.
- IDLE:
  - oReadyForCommand=1, oBusy=0, oWriteEnable=0.
  - If iCommand_Ready=1 at an edge, the engine does the following at that edge:
    - latches x=iX0, y=iY0, xStart=iX0, colour=iColor;
    - computes xEnd=min(iX0+iWidth,255) and yEnd=min(iY0+iHeight,255) with a 9-bit add (clip, never wrap);
    - moves to FILL and drops oReadyForCommand.
- FILL:
  - oBusy=1.
  - oWriteEnable = ~iHold (combinational); oWriteAddress={x,y} and oDataOut=colour (both registered).
  - First write occurs in the cycle after acceptance (latency 1).
  - On each edge with iHold=0:
    - if x<xEnd, x increments;
    - else x reloads xStart and y increments;
    - if x==xEnd and y==yEnd, go to DONE instead.
  - Scan order is row-major: x inner, y outer.
  - With iHold=1 the counters and outputs freeze and no write occurs; the next iHold=0 cycle writes the same pixel.
- DONE:
  - oDone=1 and oBusy=0 for exactly one cycle, then return to IDLE.
  - oReadyForCommand re-asserts on the cycle after oDone.
- Write count is exactly (xEnd-iX0+1)*(yEnd-iY0+1).
  - Minimum is 1: iWidth=iHeight=0 gives a single pixel.
  - Maximum is 65536: origin 0, size 255/255, taking 65536 FILL cycles.
- Commands presented in FILL or DONE are ignored; they are not queued.
- Input values other than iCommand_Ready and iHold only matter at the acceptance edge.
- Reset asserted mid-fill aborts immediately. No further writes occur and no oDone pulse is produced.
- iHold during IDLE or DONE has no effect.

Decomposition:
- Shared package `vga_defs`:
  - VGA_COORD_W=8, VGA_COLOR_W=3, VGA_ADDR_W=16.
  - State encodings ST_IDLE, ST_FILL, ST_DONE.
  - Colour constants (COLOR_BLACK..COLOR_WHITE).
- One natural sub-module: `rect_scan_counter`.
  - Holds the x/y counter pair with xStart reload and the xEnd/yEnd compare.
  - Outputs a combinational last-pixel flag.
  - Is advanced by an enable.
- The top level keeps the FSM, the clip computation and the handshake.

Test Plan:
- Reset low for 3 clocks, then release → all outputs 0 during reset; oReadyForCommand=1 on the first edge after release.
- Command X0=10, Y0=20, W=2, H=1, colour 3'b100 → 6 writes at {10,20},{11,20},{12,20},{10,21},{11,21},{12,21}, data 3'b100; oDone pulses once the cycle after the last write.
- Clip case X0=254, Y0=255, W=5, H=3 → exactly 2 writes at {254,255},{255,255}; no writes at x=0 or y=0.
- Hold case X0=0, Y0=0, W=3, H=0 with iHold=1 on the 2nd and 3rd FILL cycles → 4 writes, addresses 0x0000, 0x0100, 0x0200, 0x0300; address stays 0x0100 while held; total FILL time 6 cycles.
- Second command pulsed mid-fill, then Reset low after 5 writes of a 16x16 fill → second command is ignored; write enable drops asynchronously; no oDone; oReadyForCommand=1 after release.
- Full screen X0=0, Y0=0, W=255, H=255 → 65536 writes; last address 0xFFFF; oDone once; a scoreboard model of the RAM contents matches.
